// File: rtl/aes_block_tx.sv
// Sends a captured 128-bit AES block to a byte-wide UART, most significant byte first.
// Bytes are paced by the UART's tx_done handshake, with optional idle gaps between bytes.
module aes_block_tx #(
  parameter int NUM_BYTES  = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] block_in,
  input  logic         tx_done,
  output logic         transmit,
  output logic [7:0]   tx_byte,
  output logic         busy,
  output logic         done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEND      = 3'd1;
  localparam logic [2:0] S_WAIT_DONE = 3'd2;
  localparam logic [2:0] S_GAP       = 3'd3;
  localparam logic [2:0] S_FINISH    = 3'd4;

  localparam int             GW       = $clog2(GAP_CYCLES + 2);
  localparam logic [GW-1:0]  GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [4:0]     LAST_CNT = 5'(NUM_BYTES);

  logic [2:0]    state_q, state_d;
  logic [127:0]  shadow_q, shadow_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [3:0]    byte_sel;

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    tx_byte_d = tx_byte_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shadow_d = block_in;
          cnt_d    = 5'd0;
          state_d  = S_SEND;
        end
      end
      S_SEND: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (tx_done) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_d == LAST_CNT) begin
            state_d = S_FINISH;
          end else if (GAP_CYCLES == 0) begin
            state_d = S_SEND;
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_SEND;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Load the outgoing byte on the edge that enters SEND so it is valid alongside transmit.
    byte_sel = 4'd15 - cnt_d[3:0];
    if (state_d == S_SEND && state_q != S_SEND) begin
      tx_byte_d = shadow_d[{byte_sel, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shadow_q  <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      tx_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  assign transmit = (state_q == S_SEND);
  assign tx_byte  = tx_byte_q;
  assign busy     = (state_q == S_SEND) || (state_q == S_WAIT_DONE) || (state_q == S_GAP);
  assign done     = (state_q == S_FINISH);

endmodule

// File: tb/tb_aes_block_tx.sv
// Scoreboard bench for aes_block_tx: expected bytes are queued when a block is started
// and popped as transmit pulses appear; a second instance exercises zero-gap pacing.
module tb_aes_block_tx;

  localparam int GAP = 2;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] block_in;
  logic         tx_done, tx_done_resp, tx_done_spur;
  logic         transmit;
  logic [7:0]   tx_byte;
  logic         busy, done;

  logic         start2, td2, tx2, busy2, done2;
  logic [127:0] blk2;
  logic [7:0]   byte2;

  assign tx_done = tx_done_resp | tx_done_spur;

  aes_block_tx #(.NUM_BYTES(16), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .block_in(block_in), .tx_done(tx_done),
    .transmit(transmit), .tx_byte(tx_byte), .busy(busy), .done(done)
  );

  aes_block_tx #(.NUM_BYTES(4), .GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .start(start2), .block_in(blk2), .tx_done(td2),
    .transmit(tx2), .tx_byte(byte2), .busy(busy2), .done(done2)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         n_tx     = 0;
  int         n_ack    = 0;
  int         last_ack_cyc = -100;
  int         last_tx_cyc  = -100;
  int         exp_first_cyc = 0;
  int         blk_idx  = 0;
  int         done_pend = 0;
  logic [7:0] exp_q[$];
  logic       spur_gap = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_block(input logic [127:0] b);
    for (int i = 0; i < 16; i++) exp_q.push_back(b[127 - 8*i -: 8]);
    done_pend++;
  endtask

  // Called just after a rising edge; start is sampled on the next edge.
  task automatic send_block(input logic [127:0] b);
    block_in = b;
    push_block(b);
    exp_first_cyc = cyc + 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_tx(input int target);
    for (int t = 0; t < 3000 && n_tx < target; t++) begin
      @(posedge clk); #1;
    end
    check_eq("wait_tx", 128'(n_tx >= target), 128'd1);
  endtask

  task automatic wait_ack(input int target);
    for (int t = 0; t < 3000 && n_ack < target; t++) begin
      @(posedge clk); #1;
    end
    check_eq("wait_ack", 128'(n_ack >= target), 128'd1);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 6000 && done_pend > 0; t++) begin
      @(posedge clk); #1;
    end
    check_eq("wait_idle", 128'(done_pend), 128'd0);
  endtask

  task automatic run_gap0(input logic [127:0] b);
    int ack_cyc;
    int first_cyc;
    int k;
    blk2 = b;
    first_cyc = cyc + 1;
    ack_cyc = 0;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!tx2 && k < 200);
      check_eq("g0_seen", 128'(tx2), 128'd1);
      check_eq("g0_byte", 128'(byte2), 128'(b[127 - 8*i -: 8]));
      check_eq("g0_lat", 128'(cyc), 128'(i == 0 ? first_cyc : ack_cyc + 1));
      $display("gap0 byte %0d: %02h at cycle %0d", i, byte2, cyc);
      // A tx_done during the SEND cycle itself must not count as an acknowledgement.
      td2 = 1'b1;
      @(posedge clk); #1;
      td2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      td2 = 1'b1;
      ack_cyc = cyc;
      @(posedge clk); #1;
      td2 = 1'b0;
    end
    @(negedge clk);
    check_eq("g0_done", 128'(done2), 128'd1);
    check_eq("g0_done_lat", 128'(cyc - ack_cyc), 128'd1);
    @(negedge clk);
    check_eq("g0_busy_after", 128'(busy2), 128'd0);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // UART model: acknowledges each byte ten cycles after its transmit pulse.
  initial begin
    tx_done_resp = 1'b0;
    tx_done_spur = 1'b0;
    forever begin
      @(negedge clk);
      if (transmit) begin
        repeat (10) @(posedge clk);
        #1 tx_done_resp = 1'b1;
        @(posedge clk); #1;
        tx_done_resp = 1'b0;
        if (spur_gap) begin
          tx_done_spur = 1'b1;
          @(posedge clk); #1;
          tx_done_spur = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (tx_done_resp) begin
      n_ack++;
      last_ack_cyc = cyc;
    end
    if (transmit) begin
      n_tx++;
      check_eq("busy_tx", 128'(busy), 128'd1);
      check_eq("no_b2b_tx", 128'(cyc == last_tx_cyc + 1), 128'd0);
      last_tx_cyc = cyc;
      if (exp_q.size() == 0) begin
        check_eq("tx_unexpected", 128'(exp_q.size()), 128'd1);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        $display("tx byte %0d: got %02h expected %02h at cycle %0d", blk_idx, tx_byte, e, cyc);
        check_eq("tx_byte", 128'(tx_byte), 128'(e));
      end
      if (blk_idx == 0) check_eq("first_lat", 128'(cyc), 128'(exp_first_cyc));
      else              check_eq("gap_lat", 128'(cyc - last_ack_cyc), 128'(GAP + 1));
      blk_idx++;
    end
    if (done) begin
      $display("done pulse at cycle %0d after %0d bytes", cyc, blk_idx);
      check_eq("busy_done", 128'(busy), 128'd0);
      check_eq("done_lat", 128'(cyc - last_ack_cyc), 128'd1);
      check_eq("done_bytes", 128'(blk_idx), 128'd16);
      check_eq("done_expected", 128'(done_pend > 0), 128'd1);
      if (done_pend > 0) done_pend--;
      blk_idx = 0;
      if (start) exp_first_cyc = cyc + 2;
    end
  end

  initial begin
    int base;
    rst_n = 1'b0; start = 1'b0; block_in = '0;
    start2 = 1'b0; td2 = 1'b0; blk2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_transmit", 128'(transmit), 128'd0);
    check_eq("rst_tx_byte", 128'(tx_byte), 128'd0);
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_done", 128'(done), 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Spurious acknowledge while idle.
    tx_done_spur = 1'b1;
    @(posedge clk); #1;
    tx_done_spur = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_spur_busy", 128'(busy), 128'd0);

    // Reference block, with a spurious acknowledge in each gap.
    spur_gap = 1'b1;
    send_block(128'h00112233445566778899AABBCCDDEEFF);
    wait_idle();
    spur_gap = 1'b0;

    // Restart attempt and input change mid-block are ignored.
    base = n_tx;
    send_block(128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0);
    wait_tx(base + 3);
    block_in = {16{8'hA5}};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // Reset after the fifth acknowledge aborts the block.
    base = n_ack;
    send_block(128'hDEADBEEF0123456789ABCDEFFEDCBA98);
    wait_ack(base + 5);
    rst_n = 1'b0;
    exp_q.delete();
    done_pend = 0;
    blk_idx = 0;
    #1;
    check_eq("mid_rst_transmit", 128'(transmit), 128'd0);
    check_eq("mid_rst_tx_byte", 128'(tx_byte), 128'd0);
    check_eq("mid_rst_busy", 128'(busy), 128'd0);
    check_eq("mid_rst_done", 128'(done), 128'd0);
    base = n_tx;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_no_tx", 128'(n_tx), 128'(base));
    rst_n = 1'b1;
    send_block(128'h112233445566778899AABBCCDDEEFF00);
    wait_idle();

    // Start held high: two back-to-back blocks with different contents.
    base = n_tx;
    block_in = 128'hCAFEBABE00000000FFFFFFFF13579BDF;
    push_block(128'hCAFEBABE00000000FFFFFFFF13579BDF);
    push_block(128'h2468ACE0F1E2D3C4B5A6978877665544);
    exp_first_cyc = cyc + 1;
    start = 1'b1;
    wait_tx(base + 1);
    block_in = 128'h2468ACE0F1E2D3C4B5A6978877665544;
    wait_tx(base + 17);
    start = 1'b0;
    wait_idle();
    check_eq("b2b_count", 128'(n_tx - base), 128'd32);

    run_gap0(128'h8899AABBCCDDEEFF0011223344556677);

    repeat (20) @(posedge clk);
    #1;
    check_eq("final_queue", 128'(exp_q.size()), 128'd0);
    check_eq("final_done_pend", 128'(done_pend), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
